dma_rd_req_gen: RTL

//   Read-request generator for the host->DDR copy path. Pops one DMA descriptor
//   (source line address + length in lines) from the descriptor FIFO, splits it

---
 rtl/dma_pkg.sv | 28 ++
 rtl/dma_credit_counter.sv | 49 ++++
 rtl/dma_rd_req_gen.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
//   Shared types and constants for the DMA read/write request generators.
//   - t_rd_req_state   : read-request generator FSM encoding
//   - t_dma_descriptor : descriptor layout (source line address + length)
//   - DMA_LINE_BYTES   : bytes per data beat (addresses are line-aligned)
//   - DMA_PAGE_BYTES   : 4KB page size used by the optional burst split
// -----------------------------------------------------------------------------
package dma_pkg;

   localparam int DMA_ADDR_W      = 64;
   localparam int DMA_LEN_W       = 32;
   localparam int DMA_LINE_BYTES  = 64;
   localparam int DMA_PAGE_BYTES  = 4096;
   localparam int DMA_PAGE_OFFS_W = 12;

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_ISSUE = 2'd1,
      RD_DRAIN = 2'd2
   } t_rd_req_state;

   typedef struct packed {
      logic [DMA_ADDR_W-1:0] src_addr;
      logic [DMA_LEN_W-1:0]  len;
   } t_dma_descriptor;

endpackage

// File: rtl/dma_credit_counter.sv
// -----------------------------------------------------------------------------
// dma_credit_counter
//   Up/down saturating counter used as an outstanding-burst credit pool.
//   Shared by the read- and write-side request generators.
//   A simultaneous inc and dec nets to zero. A dec while empty and an inc
//   while full (without a paired dec) are ignored.
// Ports
//   clk      in   clock
//   reset_n  in   async active-low reset, loads INIT
//   inc      in   return one credit
//   dec      in   consume one credit
//   count    out  current credit count
//   empty    out  count == 0
//   full     out  count == MAX
// -----------------------------------------------------------------------------
module dma_credit_counter #(
   parameter int MAX   = 32,
   parameter int INIT  = MAX,
   parameter int CNT_W = $clog2(MAX + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   logic inc_en;
   logic dec_en;

   assign empty  = (count == '0);
   assign full   = (count == CNT_W'(MAX));
   assign dec_en = dec && !empty;
   // An inc at full is only legal when the same cycle consumes a credit.
   assign inc_en = inc && (!full || dec_en);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= CNT_W'(INIT);
      end else if (inc_en && !dec_en) begin
         count <= count + CNT_W'(1);
      end else if (dec_en && !inc_en) begin
         count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/dma_rd_req_gen.sv
// -----------------------------------------------------------------------------
// dma_rd_req_gen
//   Read-request generator for the host->DDR copy path. Pops one descriptor
//   from the descriptor FIFO, splits it into AXI-MM AR bursts and meters them
//   against an outstanding-burst credit pool. Pulses done once every issued
//   burst has returned its last read beat.
//
// Configuration
//   DMA_RD_REQ_4K_SPLIT_EN : when defined, a burst is also capped at the lines
//   left before the next 4KB boundary, so no burst crosses a 4KB page. When
//   undefined, bursts are limited only by MAX_BURST and the remaining length.
//   The split assumes LINE_BYTES < 4096.
//
// Ports
//   clk, reset_n   clock, async active-low reset
//   desc_valid     descriptor FIFO not empty
//   desc_src_addr  source byte address (line-aligned)
//   desc_len       transfer length in lines
//   desc_rdack     one-cycle dequeue pulse to the descriptor FIFO
//   arvalid/arready/araddr/arlen/arid   AR channel (arlen = beats-1)
//   rlast_ack      rvalid & rready & rlast from the data path
//   busy           descriptor in progress
//   done           one-cycle completion pulse
// -----------------------------------------------------------------------------
module dma_rd_req_gen
   import dma_pkg::*;
#(
   parameter int ADDR_W          = DMA_ADDR_W,
   parameter int LEN_W           = DMA_LEN_W,
   parameter int LINE_BYTES      = DMA_LINE_BYTES,
   parameter int BURST_W         = 8,
   parameter int MAX_BURST       = 64,
   parameter int MAX_OUTSTANDING = 32,
   parameter int ID_W            = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               desc_valid,
   input  logic [ADDR_W-1:0]  desc_src_addr,
   input  logic [LEN_W-1:0]   desc_len,
   output logic               desc_rdack,
   output logic               arvalid,
   input  logic               arready,
   output logic [ADDR_W-1:0]  araddr,
   output logic [BURST_W-1:0] arlen,
   output logic [ID_W-1:0]    arid,
   input  logic               rlast_ack,
   output logic               busy,
   output logic               done
);

   localparam int LINE_SHIFT = $clog2(LINE_BYTES);
   localparam int CNT_W      = $clog2(MAX_OUTSTANDING + 1);

   t_rd_req_state state_q;
   t_rd_req_state state_d;

   logic [ADDR_W-1:0]  addr_q;
   logic [LEN_W-1:0]   remain_q;
   logic [ID_W-1:0]    arid_q;
   logic [BURST_W-1:0] arlen_p0;
   logic               vld_p0;

   logic [LEN_W-1:0]   cap_lines;
   logic [LEN_W-1:0]   beats_calc;
   logic [LEN_W-1:0]   beats;
   logic               ar_hs;

   logic [CNT_W-1:0]   cr_count;
   logic               cr_empty;
   logic               cr_full;

   // ---- stage p0: size of the next burst, computed from registered state ----
   always_comb begin
      cap_lines = LEN_W'(MAX_BURST);
`ifdef DMA_RD_REQ_4K_SPLIT_EN
      // Lines left in the current 4KB page; never 0 for a line-aligned address.
      if ((LEN_W'(DMA_PAGE_BYTES / LINE_BYTES) -
           LEN_W'(addr_q[DMA_PAGE_OFFS_W-1:LINE_SHIFT])) < cap_lines) begin
         cap_lines = LEN_W'(DMA_PAGE_BYTES / LINE_BYTES) -
                     LEN_W'(addr_q[DMA_PAGE_OFFS_W-1:LINE_SHIFT]);
      end
`endif
      beats_calc = (remain_q < cap_lines) ? remain_q : cap_lines;
   end

   assign beats  = LEN_W'(arlen_p0) + LEN_W'(1);
   assign ar_hs  = arvalid && arready;
   assign araddr = addr_q;
   assign arlen  = arlen_p0;
   assign arid   = arid_q;

   dma_credit_counter #(
      .MAX   (MAX_OUTSTANDING),
      .INIT  (MAX_OUTSTANDING),
      .CNT_W (CNT_W)
   ) u_credits (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (rlast_ack),
      .dec     (ar_hs),
      .count   (cr_count),
      .empty   (cr_empty),
      .full    (cr_full)
   );

   // ---- FSM state register ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RD_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---- FSM next state ----
   always_comb begin
      state_d = state_q;
      case (state_q)
         RD_IDLE: begin
            if (desc_valid) begin
               state_d = (desc_len == '0) ? RD_DRAIN : RD_ISSUE;
            end
         end
         RD_ISSUE: begin
            if (ar_hs && (remain_q == beats)) begin
               state_d = RD_DRAIN;
            end
         end
         RD_DRAIN: begin
            if (cr_full) begin
               state_d = RD_IDLE;
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   // ---- FSM outputs ----
   // arvalid depends only on registered state, so it cannot react to arready
   // in the same cycle; once raised it holds until the handshake because
   // credits only drop on that handshake.
   always_comb begin
      desc_rdack = 1'b0;
      arvalid    = 1'b0;
      done       = 1'b0;
      busy       = 1'b0;
      case (state_q)
         RD_IDLE:  desc_rdack = desc_valid;
         RD_ISSUE: begin
            arvalid = vld_p0 && !cr_empty;
            busy    = 1'b1;
         end
         RD_DRAIN: begin
            done = cr_full;
            busy = !cr_full;
         end
         default: ;
      endcase
   end

   // ---- stage p0 -> AR: descriptor latch, burst sizing and address walk ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q   <= '0;
         remain_q <= '0;
         arid_q   <= '0;
         arlen_p0 <= '0;
         vld_p0   <= 1'b0;
      end else begin
         case (state_q)
            RD_IDLE: begin
               vld_p0 <= 1'b0;
               if (desc_valid) begin
                  addr_q   <= desc_src_addr;
                  remain_q <= desc_len;
               end
            end
            RD_ISSUE: begin
               if (ar_hs) begin
                  // Address wraps at 2**ADDR_W; beats <= remain_q by construction.
                  addr_q   <= addr_q + (ADDR_W'(beats) << LINE_SHIFT);
                  remain_q <= remain_q - beats;
                  arid_q   <= arid_q + ID_W'(1);
                  vld_p0   <= 1'b0;
               end else if (!vld_p0) begin
                  arlen_p0 <= BURST_W'(beats_calc - LEN_W'(1));
                  vld_p0   <= 1'b1;
               end
            end
            default: vld_p0 <= 1'b0;
         endcase
      end
   end

`ifndef SYNTHESIS
   // A returned burst with the pool already full means the data path saw more
   // rlast beats than bursts issued; the counter ignores it.
   a_credit_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(rlast_ack && (cr_count == CNT_W'(MAX_OUTSTANDING)) && !ar_hs));
`endif

endmodule
